// File: rtl/aux_burst_reader_pkg.sv
// Shared state encoding, parameter defaults and audio word field bounds.
// Pure declarations; no timing or flow-control behaviour of its own.
package aux_burst_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BURST,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [11:0] START_H_DEF    = 12'd1530;
    localparam int          BURST_LEN_DEF  = 32;
    localparam int          GAP_LEN_DEF    = 4;
    localparam int          MAX_BURSTS_DEF = 8;

    localparam int TAG_HI = 11;
    localparam int TAG_LO = 8;
    localparam int PAY_HI = 7;
    localparam int PAY_LO = 0;

    localparam int BEAT_W = 6;

    function automatic logic [TAG_HI-TAG_LO:0] word_tag(input logic [11:0] w);
        return w[TAG_HI:TAG_LO];
    endfunction

endpackage

// File: rtl/aux_burst_reader_if.sv
// Read port of the receive audio FIFO (show-ahead data, one-cycle registered copy downstream).
// The reader pulls with o_rd_en; the FIFO exerts backpressure only through i_empty.
interface aux_burst_reader_if;
    logic        o_rd_en;
    logic        i_empty;
    logic [11:0] i_q;

    modport master (output o_rd_en, input i_empty, input i_q);
    modport slave  (input o_rd_en, output i_empty, output i_q);
endinterface

// File: rtl/aux_frame_detect.sv
// Per-frame audio presence flag: sticky "FIFO ever non-empty" bit, published at i_vcnt==0.
// One-cycle registered update; no backpressure.
module aux_frame_detect (
    input  logic        fifo_clk,
    input  logic        sys_rst,
    input  logic [11:0] i_vcnt,
    input  logic        i_empty,
    output logic        o_audio_on
);

    logic seen;

    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            seen       <= 1'b0;
            o_audio_on <= 1'b0;
        end else begin
            if (i_vcnt == 12'd0) begin
                o_audio_on <= seen;
            end
            // A word arriving on the frame boundary counts toward the next frame.
            if (!i_empty) begin
                seen <= 1'b1;
            end else if (i_vcnt == 12'd0) begin
                seen <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aux_burst_reader.sv
// Drains the audio FIFO in fixed-length bursts during horizontal blanking; o_ax_* lag o_rd_en by 1.
// FIFO empty gates o_rd_en combinationally and aborts the line; active video preempts any burst.
module aux_burst_reader
    import aux_burst_reader_pkg::*;
#(
    parameter logic [11:0] START_H    = START_H_DEF,
    parameter int          BURST_LEN  = BURST_LEN_DEF,
    parameter int          GAP_LEN    = GAP_LEN_DEF,
    parameter int          MAX_BURSTS = MAX_BURSTS_DEF
) (
    input  logic               fifo_clk,
    input  logic               sys_rst,
    input  logic [11:0]        i_hcnt,
    input  logic [11:0]        i_vcnt,
    input  logic               i_vde,
    aux_burst_reader_if.master fifo,
    output logic [11:0]        o_ax_data,
    output logic               o_ax_valid,
    output logic               o_ade,
    output logic               o_audio_on,
    output logic               o_underflow
);

    localparam int BCW = $clog2(MAX_BURSTS + 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BCW-1:0]      burst_q, burst_d;
    logic                rd_req;
    logic                underflow_set;
    logic                more_bursts;

    assign more_bursts  = (word_tag(o_ax_data) != '0) && (burst_q < BCW'(MAX_BURSTS));
    assign fifo.o_rd_en = rd_req & ~sys_rst;
    assign o_ade        = o_ax_valid;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        burst_d       = burst_q;
        rd_req        = 1'b0;
        underflow_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_vde) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!i_vde && !fifo.i_empty && i_hcnt == START_H) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                    burst_d = '0;
                end
            end
            ST_BURST: begin
                if (i_vde) begin
                    state_d = ST_ARMED;
                    beat_d  = '0;
                end else if (fifo.i_empty) begin
                    state_d       = ST_DONE;
                    beat_d        = '0;
                    underflow_set = 1'b1;
                end else begin
                    rd_req = 1'b1;
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        state_d = ST_GAP;
                        beat_d  = '0;
                        if (burst_q != BCW'(MAX_BURSTS)) burst_d = burst_q + 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (i_vde) begin
                    state_d = ST_ARMED;
                    beat_d  = '0;
                end else if (beat_q == BEAT_W'(GAP_LEN - 1)) begin
                    beat_d  = '0;
                    state_d = more_bursts ? ST_BURST : ST_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_vde) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            burst_q     <= '0;
            o_ax_valid  <= 1'b0;
            o_ax_data   <= 12'd0;
            o_underflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            burst_q    <= burst_d;
            o_ax_valid <= fifo.o_rd_en;
            if (fifo.o_rd_en) o_ax_data <= fifo.i_q;
            if (underflow_set) o_underflow <= 1'b1;
        end
    end

    aux_frame_detect u_frame_detect (
        .fifo_clk   (fifo_clk),
        .sys_rst    (sys_rst),
        .i_vcnt     (i_vcnt),
        .i_empty    (fifo.i_empty),
        .o_audio_on (o_audio_on)
    );

endmodule

// File: doc/aux_burst_reader.md
AUX_BURST_READER -- requirements
Module: aux_burst_reader

Interface
REQ-001 Parameter START_H, default 12'd1530, hcnt value at which a line's first audio burst starts.
REQ-002 Parameter BURST_LEN, default 32, FIFO reads per burst.
REQ-003 Parameter GAP_LEN, default 4, idle cycles between consecutive bursts.
REQ-004 Parameter MAX_BURSTS, default 8, maximum bursts per line.
REQ-005 fifo_clk  in  1  sole clock, pixel clock (74.25 MHz); one clock, reset synchronous active-high.
REQ-006 sys_rst  in  1  synchronous active-high reset.
REQ-007 i_hcnt  in  12  horizontal pixel counter.
REQ-008 i_vcnt  in  12  vertical line counter.
REQ-009 i_vde  in  1  video data enable (active region).
REQ-010 i_empty  in  1  recv audio FIFO empty.
REQ-011 i_q  in  12  recv audio FIFO read data; [11:8] bursts-left tag, [7:0] payload.
REQ-012 o_rd_en  out  1  recv audio FIFO read enable.
REQ-013 o_ax_data  out  12  registered copy of i_q.
REQ-014 o_ax_valid  out  1  o_ax_data valid strobe.
REQ-015 o_ade  out  1  audio data-island enable toward the TMDS encoder.
REQ-016 o_audio_on  out  1  audio-present flag, updated once per frame.
REQ-017 o_underflow  out  1  sticky, FIFO ran empty mid-burst.

Function
REQ-018 States: IDLE, ARMED, BURST, GAP, DONE.
- IDLE -> ARMED on the first cycle i_vde=1 after reset.
REQ-019 ARMED -> BURST when i_vde=0, i_empty=0 and i_hcnt==START_H, all in the same cycle. o_rd_en rises on the next cycle. Burst counter is cleared.
REQ-020 BURST holds o_rd_en=1 for exactly BURST_LEN cycles, then enters GAP with o_rd_en=0.
REQ-021 GAP lasts GAP_LEN cycles.
- On its last cycle: if the most recently read tag i_q[11:8] > 0 and bursts issued < MAX_BURSTS, go to BURST; else go to DONE.
REQ-022 DONE -> ARMED when i_vde=1 (next active line).
REQ-023 FIFO read latency is 1 cycle:
- o_ax_valid = o_rd_en delayed by 1.
- o_ax_data = i_q registered while o_ax_valid.
- o_ade = o_ax_valid.
REQ-024 i_empty=1 during BURST: o_rd_en drops in the same cycle (combinational gate), o_underflow sets, and the FSM goes to DONE.
REQ-025 i_vde=1 in any state other than IDLE/ARMED: o_rd_en forced 0 and the FSM goes to ARMED (active video preempts audio).
REQ-026 Audio detect: a sticky seen bit sets whenever i_empty=0.
- On any cycle with i_vcnt==0: o_audio_on <= seen, and seen clears.
- If seen sets in the same cycle, the set wins.
REQ-027 Burst counter width is clog2(MAX_BURSTS+1) and never wraps; the per-burst cycle counter is 6 bits and compares against BURST_LEN-1.
REQ-028 Start is evaluated only in ARMED; i_hcnt==START_H seen in other states is ignored.

Reset
REQ-029 sys_rst=1 at any clock, including mid-burst, returns the FSM to IDLE and clears all counters.
- o_rd_en, o_ax_valid, o_ade, o_audio_on, o_underflow, seen = 0; o_ax_data = 12'd0.
- The reset cycle issues no read.

Structure
REQ-030 A shared package holds: FSM state encoding; defaults START_H/BURST_LEN/GAP_LEN/MAX_BURSTS; tag field bounds [11:8]/[7:0].
REQ-031 A single sub-module, aux_frame_detect, implements REQ-026; everything else is flat.

Verification
REQ-032 Reset release, one i_vde pulse, FIFO holding 32 words tagged 0, hcnt reaches 1530 in blanking:
- exactly 32 consecutive o_rd_en cycles;
- o_ax_valid lags o_rd_en by 1 cycle;
- FSM reaches DONE.
REQ-033 96 words, tags 2,1,0 per 32-word block: 3 bursts separated by 4-cycle gaps, 96 reads total.
REQ-034 i_empty asserts after read 10 of a burst: o_rd_en low the same cycle, o_underflow=1, exactly 10 reads.
REQ-035 i_vde asserts at read 20 mid-burst: o_rd_en=0 next edge, FSM in ARMED; next blanking at hcnt 1530 starts a new burst.
REQ-036 Frame with FIFO non-empty, then i_vcnt=0: o_audio_on=1; next frame always empty, i_vcnt=0: o_audio_on=0.
REQ-037 sys_rst pulsed mid-burst: all outputs 0 next cycle; no burst before a new i_vde pulse.
